brick_hit_handler: RTL and testbench

//  Consumes brick-collision pulses from the ball collision stage: collided_1/col_x1/col_y1 (vertical hit)
//  and collided_2/col_x2/col_y2 (horizontal hit). For each hit it read-modify-writes the brick health

---
 rtl/brick_pkg.sv | 38 +++
 rtl/hit_fifo.sv | 75 +++++++
 rtl/brick_hit_handler.sv | 191 +++++++++++++++++++
 tb/tb_brick_hit_handler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared definitions for the brick hit handler.
// Holds the default brick geometry, the health and coordinate widths, the
// colour palette for redraws, the handler FSM state encoding and the
// health-to-colour mapping used when a brick is redrawn.
package brick_pkg;

    localparam int BRICKX_LOG2_DEF = 5;    // 32 px wide bricks
    localparam int BRICKY_LOG2_DEF = 4;    // 16 px tall bricks
    localparam int HEALTH_W        = 2;
    localparam int COORD_W         = 10;
    localparam int ENTRY_W         = 2 * COORD_W;   // queued entry is {x, y}

    localparam logic [2:0] COL_ERASE = 3'b000;
    localparam logic [2:0] COL_H1    = 3'b100;
    localparam logic [2:0] COL_H2    = 3'b110;
    localparam logic [2:0] COL_H3    = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_UPDATE = 3'd2,
        S_DRAW   = 3'd3,
        S_POP    = 3'd4
    } state_t;

    // Colour for a brick given its health after the hit; health 0 erases it.
    function automatic logic [2:0] health_colour(input logic [HEALTH_W-1:0] h);
        logic [2:0] c;
        case (h)
            2'd0:    c = COL_ERASE;
            2'd1:    c = COL_H1;
            2'd2:    c = COL_H2;
            default: c = COL_H3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hit_fifo.sv
// Pending-hit queue for the brick hit handler.
// Dual-push, single-pop FIFO of {x, y} entries. When both pushes fire in one
// cycle, data_a is stored ahead of data_b; a lone push_b takes the first slot.
// The caller is responsible for never pushing more entries than free_cnt.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   push_a/data_a      first push slot
//   push_b/data_b      second push slot
//   pop                remove head (ignored when empty)
//   head               oldest entry
//   empty, full        occupancy flags (wrap-bit pointers)
//   free_cnt           number of free slots
//   cmp_a/cmp_b        values compared against the most recently pushed entry
//   match_a/match_b    compare hit; only while that entry is still queued
module hit_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_a,
    input  logic [W-1:0]           data_a,
    input  logic                   push_b,
    input  logic [W-1:0]           data_b,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] free_cnt,
    input  logic [W-1:0]           cmp_a,
    input  logic [W-1:0]           cmp_b,
    output logic                   match_a,
    output logic                   match_b
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] last_idx;
    logic [PTR_W-1:0] b_idx;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign free_cnt = (PTR_W+1)'(DEPTH) - count;
    assign head     = store[rd_ptr[PTR_W-1:0]];

    // The newest entry is always the last to leave, so it is still queued
    // exactly as long as the FIFO is non-empty.
    assign last_idx = wr_ptr[PTR_W-1:0] - PTR_W'(1);
    assign match_a  = !empty && (store[last_idx] == cmp_a);
    assign match_b  = !empty && (store[last_idx] == cmp_b);

    assign b_idx    = wr_ptr[PTR_W-1:0] + PTR_W'(push_a);

    always_ff @(posedge clk) begin
        if (push_a) store[wr_ptr[PTR_W-1:0]] <= data_a;
        if (push_b) store[b_idx]             <= data_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(push_a) + (PTR_W+1)'(push_b);
            if (pop && !empty) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/brick_hit_handler.sv
// Brick hit handler.
// Takes collision pulses from the ball logic, queues the hit bricks, and for
// each queued brick read-modify-writes its health in the brick RAM, asks the
// VGA drawer to repaint it, and keeps the score and live-brick count.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   hit_y, hit_y_x, hit_y_y  vertical collision pulse and brick origin
//   hit_x, hit_x_x, hit_x_y  horizontal collision pulse and brick origin
//   mem_addr, mem_rdata      brick RAM address / read data (1-cycle latency)
//   mem_wdata, mem_we        brick RAM write data / strobe
//   draw_req, draw_ack       redraw handshake (req held until ack)
//   draw_x, draw_y           brick origin to repaint
//   draw_colour              colour for the new health
//   score                    saturating hit counter
//   bricks_left, all_cleared live-brick count and its zero flag
//   busy                     work in progress or queued
//   overflow                 sticky: a hit was lost to a full queue
module brick_hit_handler
    import brick_pkg::*;
#(
    parameter int BRICKX_LOG2  = BRICKX_LOG2_DEF,
    parameter int BRICKY_LOG2  = BRICKY_LOG2_DEF,
    parameter int GRID_COLS    = 16,
    parameter int GRID_ROWS    = 8,
    parameter int ADDR_W       = 7,
    parameter int TOTAL_BRICKS = 128,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hit_y,
    input  logic [9:0]          hit_y_x,
    input  logic [9:0]          hit_y_y,
    input  logic                hit_x,
    input  logic [9:0]          hit_x_x,
    input  logic [9:0]          hit_x_y,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [1:0]          mem_rdata,
    output logic [1:0]          mem_wdata,
    output logic                mem_we,
    output logic                draw_req,
    output logic [9:0]          draw_x,
    output logic [9:0]          draw_y,
    output logic [2:0]          draw_colour,
    input  logic                draw_ack,
    output logic [15:0]         score,
    output logic [ADDR_W:0]     bricks_left,
    output logic                all_cleared,
    output logic                busy,
    output logic                overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // ---------------- capture ----------------
    logic [9:0] y_col, y_row, x_col, x_row;
    logic       y_valid, x_valid, same_brick;
    logic       y_ok, x_ok, x_dup;
    logic       push_y, push_x, drop;

    logic [ENTRY_W-1:0] y_ent, x_ent, head;
    logic               fifo_empty, fifo_full, match_y, match_x, pop;
    logic [PTR_W:0]     free_cnt;

    assign y_col   = hit_y_x >> BRICKX_LOG2;
    assign y_row   = hit_y_y >> BRICKY_LOG2;
    assign x_col   = hit_x_x >> BRICKX_LOG2;
    assign x_row   = hit_x_y >> BRICKY_LOG2;
    assign y_valid = hit_y && (int'(y_col) < GRID_COLS) && (int'(y_row) < GRID_ROWS);
    assign x_valid = hit_x && (int'(x_col) < GRID_COLS) && (int'(x_row) < GRID_ROWS);
    assign y_ent   = {hit_y_x, hit_y_y};
    assign x_ent   = {hit_x_x, hit_x_y};
    assign same_brick = (y_col == x_col) && (y_row == x_row);

    // Filtering order: range, duplicate, capacity. Only capacity drops are
    // counted as overflow. If y is pushed it becomes the newest entry, so x
    // only needs the same-brick test against y in that case.
    assign y_ok   = y_valid && !match_y;
    assign push_y = y_ok && !fifo_full;
    assign x_dup  = (y_valid && same_brick) || (!push_y && match_x);
    assign x_ok   = x_valid && !x_dup;
    assign push_x = x_ok && (free_cnt > (PTR_W+1)'(push_y));
    assign drop   = (y_ok && !push_y) || (x_ok && !push_x);

    hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_a   (push_y),
        .data_a   (y_ent),
        .push_b   (push_x),
        .data_b   (x_ent),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .free_cnt (free_cnt),
        .cmp_a    (y_ent),
        .cmp_b    (x_ent),
        .match_a  (match_y),
        .match_b  (match_x)
    );

    // ---------------- head decode ----------------
    logic [9:0]        head_x, head_y, head_col, head_row;
    logic [ADDR_W-1:0] head_addr;

    assign head_x    = head[ENTRY_W-1:COORD_W];
    assign head_y    = head[COORD_W-1:0];
    assign head_col  = head_x >> BRICKX_LOG2;
    assign head_row  = head_y >> BRICKY_LOG2;
    // Constant multiplier; reduces to a shift when GRID_COLS is a power of 2.
    assign head_addr = ADDR_W'(32'(head_row) * 32'(GRID_COLS) + 32'(head_col));

    // ---------------- FSM ----------------
    state_t state, state_next;
    logic   load_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_addr  = 1'b0;
        pop        = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = 2'd0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    load_addr  = 1'b1;
                    state_next = S_READ;
                end
            end
            S_READ:   state_next = S_UPDATE;   // RAM read in flight
            S_UPDATE: begin
                if (mem_rdata == 2'd0) begin
                    state_next = S_POP;        // already dead: nothing to do
                end else begin
                    mem_we     = 1'b1;
                    mem_wdata  = mem_rdata - 2'd1;
                    state_next = S_DRAW;
                end
            end
            S_DRAW: begin
                if (draw_ack) state_next = S_POP;
            end
            S_POP: begin
                pop        = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr    <= '0;
            draw_req    <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_colour <= COL_ERASE;
            score       <= '0;
            bricks_left <= (ADDR_W+1)'(TOTAL_BRICKS);
            overflow    <= 1'b0;
        end else begin
            if (drop)      overflow <= 1'b1;
            if (load_addr) mem_addr <= head_addr;
            if (mem_we) begin
                if (score != 16'hFFFF) score <= score + 16'd1;
                if (mem_rdata == 2'd1 && bricks_left != '0)
                    bricks_left <= bricks_left - (ADDR_W+1)'(1);
                draw_req    <= 1'b1;
                draw_x      <= head_x;
                draw_y      <= head_y;
                draw_colour <= health_colour(mem_wdata);
            end else if (state == S_DRAW && draw_ack) begin
                draw_req <= 1'b0;
            end
        end
    end

    assign all_cleared = (bricks_left == '0);
    assign busy        = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_brick_hit_handler.sv
module tb_brick_hit_handler;

    localparam int NB    = 128;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hit_y = 1'b0, hit_x = 1'b0;
    logic [9:0] hit_y_x = '0, hit_y_y = '0, hit_x_x = '0, hit_x_y = '0;
    logic [6:0] mem_addr;
    logic [1:0] mem_rdata;
    logic [1:0] mem_wdata;
    logic       mem_we;
    logic       draw_req;
    logic [9:0] draw_x, draw_y;
    logic [2:0] draw_colour;
    logic       draw_ack = 1'b1;
    logic [15:0] score;
    logic [7:0] bricks_left;
    logic       all_cleared, busy, overflow;

    always #5 clk = ~clk;

    brick_hit_handler dut (
        .clk(clk), .reset(reset),
        .hit_y(hit_y), .hit_y_x(hit_y_x), .hit_y_y(hit_y_y),
        .hit_x(hit_x), .hit_x_x(hit_x_x), .hit_x_y(hit_x_y),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_colour(draw_colour),
        .draw_ack(draw_ack), .score(score), .bricks_left(bricks_left),
        .all_cleared(all_cleared), .busy(busy), .overflow(overflow)
    );

    // Brick RAM (environment): synchronous read, bulk preload from img.
    logic [1:0] ram [NB];
    logic [1:0] img [NB];
    logic       load_img = 1'b0;

    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (load_img) begin
            for (int i = 0; i < NB; i++) ram[i] <= img[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    // Stimulus for the next cycle.
    bit s_rst = 1, s_hy = 0, s_hx = 0, s_ack = 1, s_load = 0;
    int s_yx = 0, s_yy = 0, s_xx = 0, s_xy = 0;

    // Behavioural model: queue of encoded hits (x*1024+y), per-brick health,
    // and a stage counter following the handling timeline of one hit.
    int q[$];
    int stage;      // 0 idle, 1 read, 2 update, 3 draw, 4 pop
    int cur;
    int mh [NB];
    int m_score, m_left, m_col;
    bit m_ovf;
    int nchk = 0, nerr = 0;

    function automatic int colour_of(int h);
        case (h)
            0: return 0;
            1: return 4;
            2: return 6;
            default: return 7;
        endcase
    endfunction

    function automatic int addr_of(int e);
        return ((e % 1024) / 16) * 16 + (e / 1024) / 32;
    endfunction

    function automatic bit in_range(int x, int y);
        return (x / 32 < 16) && (y / 16 < 8);
    endfunction

    task automatic chk(string n, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        stage = 0; cur = 0;
        m_score = 0; m_left = 128; m_col = 0; m_ovf = 0;
    endtask

    task automatic model_check();
        int h;
        h = mh[addr_of(cur)];
        chk("busy", int'(busy), int'(stage != 0 || q.size() != 0));
        chk("mem_we", int'(mem_we), int'(stage == 2 && h != 0));
        if (stage == 1 || stage == 2) chk("mem_addr", int'(mem_addr), addr_of(cur));
        if (stage == 2 && h != 0) chk("mem_wdata", int'(mem_wdata), h - 1);
        chk("draw_req", int'(draw_req), int'(stage == 3));
        if (stage == 3) begin
            chk("draw_x", int'(draw_x), cur / 1024);
            chk("draw_y", int'(draw_y), cur % 1024);
            chk("draw_colour", int'(draw_colour), m_col);
        end
        chk("score", int'(score), m_score);
        chk("bricks_left", int'(bricks_left), m_left);
        chk("all_cleared", int'(all_cleared), int'(m_left == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        if (reset) begin
            chk("rst_mem_addr", int'(mem_addr), 0);
            chk("rst_draw_xy", int'(draw_x) + int'(draw_y), 0);
            chk("rst_colour", int'(draw_colour), 0);
        end
    endtask

    task automatic model_advance();
        int  push[$];
        int  free, last, e, h, a;
        bit  has_last, yv, xv;
        if (s_load) for (int i = 0; i < NB; i++) mh[i] = int'(img[i]);
        free = DEPTH - q.size();
        has_last = (q.size() != 0);
        last = has_last ? q[$] : 0;
        yv = s_hy && in_range(s_yx, s_yy);
        xv = s_hx && in_range(s_xx, s_xy);
        if (yv) begin
            e = s_yx * 1024 + s_yy;
            if (!(has_last && e == last)) begin
                if (free > 0) begin
                    push.push_back(e); free--; last = e; has_last = 1;
                end else m_ovf = 1;
            end
        end
        if (xv) begin
            e = s_xx * 1024 + s_xy;
            if (!(yv && s_xx / 32 == s_yx / 32 && s_xy / 16 == s_yy / 16) &&
                !(has_last && e == last)) begin
                if (free > 0) push.push_back(e);
                else m_ovf = 1;
            end
        end
        case (stage)
            0: if (q.size() != 0) begin cur = q[0]; stage = 1; end
            1: stage = 2;
            2: begin
                a = addr_of(cur); h = mh[a];
                if (h != 0) begin
                    mh[a] = h - 1;
                    if (m_score < 65535) m_score++;
                    if (h == 1 && m_left > 0) m_left--;
                    m_col = colour_of(h - 1);
                    stage = 3;
                end else stage = 4;
            end
            3: if (s_ack) stage = 4;
            default: begin void'(q.pop_front()); stage = 0; end
        endcase
        foreach (push[i]) q.push_back(push[i]);
    endtask

    task automatic step();
        @(posedge clk); #1;
        reset = s_rst; load_img = s_load; draw_ack = s_ack;
        hit_y = s_hy; hit_y_x = 10'(s_yx); hit_y_y = 10'(s_yy);
        hit_x = s_hx; hit_x_x = 10'(s_xx); hit_x_y = 10'(s_xy);
        @(negedge clk);
        if (reset) model_reset();
        model_check();
        if (!reset) model_advance();
    endtask

    task automatic idle(int n);
        s_hy = 0; s_hx = 0; s_load = 0;
        repeat (n) step();
    endtask

    task automatic hy(int x, int y);
        s_hy = 1; s_yx = x; s_yy = y; step(); s_hy = 0;
    endtask

    task automatic hx(int x, int y);
        s_hx = 1; s_xx = x; s_xy = y; step(); s_hx = 0;
    endtask

    task automatic hboth(int yx, int yy, int xx, int xy);
        s_hy = 1; s_yx = yx; s_yy = yy; s_hx = 1; s_xx = xx; s_xy = xy;
        step(); s_hy = 0; s_hx = 0;
    endtask

    task automatic load();
        s_load = 1; step(); s_load = 0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((stage != 0 || q.size() != 0) && n < budget) begin idle(1); n++; end
        chk("drain_done", int'(stage == 0 && q.size() == 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        for (int i = 0; i < NB; i++) begin img[i] = 2'd3; mh[i] = 3; end
        s_rst = 1; idle(2); s_rst = 0;
        load(); idle(2);

        // 1: basic hit, health 3 -> 2
        hy(64, 32); idle(3);
        chk("t1_we", int'(mem_we), 1);
        chk("t1_wdata", int'(mem_wdata), 2);
        chk("t1_addr", int'(mem_addr), 34);
        idle(1);
        chk("t1_draw_req", int'(draw_req), 1);
        chk("t1_colour", int'(draw_colour), 6);
        chk("t1_score", int'(score), 1);
        drain(20);

        // 2: kill a health-1 brick, then hit it again
        for (int i = 0; i < NB; i++) img[i] = 2'(mh[i]);
        img[51] = 2'd1; load();
        hx(96, 48); idle(3);
        chk("t2_wdata", int'(mem_wdata), 0);
        idle(1);
        chk("t2_colour", int'(draw_colour), 0);
        chk("t2_left", int'(bricks_left), 127);
        drain(20);
        hx(96, 48); drain(20);
        chk("t2_score", int'(score), 2);
        chk("t2_left_again", int'(bricks_left), 127);

        // 3: simultaneous hits, different then same brick
        hboth(0, 0, 32, 0); idle(2);
        chk("t3_y_first", int'(mem_addr), 0);
        drain(30);
        chk("t3_score2", int'(score), 4);
        hboth(160, 16, 160, 16); drain(30);
        chk("t3_score1", int'(score), 5);

        // 4: queue fills while the drawer stalls
        s_ack = 0;
        for (int c = 0; c < 6; c++) hy(c * 32, 64);
        idle(2);
        chk("t4_overflow", int'(overflow), 1);
        s_ack = 1; drain(60);
        chk("t4_score", int'(score), 9);

        // 5: out-of-range hit
        hy(600, 0); idle(1);
        chk("t5_busy", int'(busy), 0);
        idle(2);
        chk("t5_busy_later", int'(busy), 0);

        // 6: reset in the middle of a draw
        s_ack = 0; hy(0, 32); idle(4);
        chk("t6_draw_req", int'(draw_req), 1);
        @(posedge clk); #1;
        reset = 1; s_rst = 1; hit_y = 0; hit_x = 0;
        #1;
        chk("t6_req_dropped", int'(draw_req), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_score", int'(score), 0);
        chk("t6_ovf", int'(overflow), 0);
        @(negedge clk); model_reset(); model_check();
        idle(1); s_rst = 0; s_ack = 1; idle(2);

        // 7: randomized traffic
        for (int i = 0; i < NB; i++) img[i] = 2'($urandom_range(0, 3));
        load();
        for (int n = 0; n < 2500; n++) begin
            s_hy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) begin
                s_yx = $urandom_range(0, 18) * 32; s_yy = $urandom_range(0, 9) * 16;
            end
            s_hx = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin s_xx = s_yx; s_xy = s_yy; end
            else begin s_xx = $urandom_range(0, 18) * 32; s_xy = $urandom_range(0, 9) * 16; end
            s_ack = ($urandom_range(0, 2) != 0);
            step();
        end
        s_hy = 0; s_hx = 0; s_ack = 1; drain(60);

        // 8: clear every brick, then a kill with bricks_left already 0
        s_rst = 1; idle(2); s_rst = 0;
        for (int i = 0; i < NB; i++) img[i] = 2'd1;
        load();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) begin
                hy(c * 32, r * 16); drain(20);
            end
        chk("t8_left", int'(bricks_left), 0);
        chk("t8_cleared", int'(all_cleared), 1);
        chk("t8_score", int'(score), 128);
        for (int i = 0; i < NB; i++) img[i] = 2'd0;
        img[0] = 2'd1; load();
        hy(0, 0); drain(20);
        chk("t8_left_floor", int'(bricks_left), 0);
        chk("t8_score_after", int'(score), 129);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
